// File: rtl/dmem_responder.sv
// Multi-cycle word data memory: accepts one request per req/ready handshake,
// waits LATENCY cycles, then returns load data or commits the store.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int unsigned WORDS = 2 ** DEPTH_LOG2;
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  we_q;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic                  capture;
    logic                  enter_resp;
    logic                  fault;
    logic                  mem_wr;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           mem [WORDS];

    // All fault and index decoding works on the latched request, never the live bus.
    assign idx   = addr_q[DEPTH_LOG2+1:2];
    assign fault = (addr_q[1:0] != 2'b00) || (addr_q[31:DEPTH_LOG2+2] != '0);

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        capture    = 1'b0;
        enter_resp = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    cnt_d   = LAT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    enter_resp = 1'b1;
                    cnt_d      = 4'd0;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (enter_resp) begin
            err_d = fault;
            if (fault) begin
                rdata_d = '0;
            end else if (!we_q) begin
                rdata_d = mem[idx];
            end
        end
    end

    // A reset on the committing edge must still suppress the store.
    assign mem_wr = enter_resp && we_q && !fault && !reset;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture && !reset) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // NOTE: the storage array has no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[idx] <= wdata_q;
        end
    end

    assign ready = (state_q == S_RESP);
    assign busy  = (state_q != S_IDLE);
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule
